// File: rtl/mc_rf_pkg.sv
// Shared types and constants for the refresh scheduler slice.
// Optional feature macro used by this slice: MC_RF_URGENT_EN.
package mc_rf_pkg;

  localparam int RF_TIME_W = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    START = 2'd2,
    BUSY  = 2'd3
  } rf_state_e;

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } tmr_state_e;

  // Reload value after a tick: a period of 0 behaves like a period of 1.
  function automatic logic [RF_TIME_W-1:0] rf_reload_val(input logic [RF_TIME_W-1:0] period);
    logic [RF_TIME_W-1:0] val;
    if (period == {RF_TIME_W{1'b0}}) begin
      val = {RF_TIME_W{1'b0}};
    end else begin
      val = period - RF_TIME_W'(1);
    end
    return val;
  endfunction

endpackage

// File: rtl/mc_rf_timer.sv
// Refresh interval timer: loads the start delay on enable, then ticks once
// per period. The tick is combinational in the cycle where the count is zero.
module mc_rf_timer
  import mc_rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mc_rf_en,
  input  logic [RF_TIME_W-1:0] start_cfg,
  input  logic [RF_TIME_W-1:0] period_cfg,
  output logic                 tick
);

  tmr_state_e           state_r;
  logic [RF_TIME_W-1:0] cnt_r;
  logic                 tick_s;

  // Tick only while running and still enabled; dropping enable suppresses it.
  always_comb begin
    tick_s = 1'b0;
    if ((state_r == RUN) && mc_rf_en && (cnt_r == {RF_TIME_W{1'b0}})) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  assign tick = tick_s;

  // Timer state and down-counter; configuration is only sampled at load/reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= OFF;
      cnt_r   <= {RF_TIME_W{1'b0}};
    end else begin
      case (state_r)
        OFF: begin
          if (mc_rf_en) begin
            state_r <= RUN;
            cnt_r   <= start_cfg;
          end
        end
        RUN: begin
          if (!mc_rf_en) begin
            state_r <= OFF;
            cnt_r   <= {RF_TIME_W{1'b0}};
          end else if (tick_s) begin
            cnt_r <= rf_reload_val(period_cfg);
          end else begin
            cnt_r <= cnt_r - RF_TIME_W'(1);
          end
        end
        default: begin
          state_r <= OFF;
          cnt_r   <= {RF_TIME_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/mc_rf_scheduler.sv
// Refresh scheduler: counts owed refreshes from the interval timer, requests
// the access arbiter, pulses rf_start on grant and waits for rf_finish.
// Optional feature macro: MC_RF_URGENT_EN (drives rf_urgent when defined).
module mc_rf_scheduler
  import mc_rf_pkg::*;
#(
  parameter int PEND_W     = 4,
  parameter int MAX_PEND   = 8,
  parameter int URGENT_THR = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mc_rf_en,
  input  logic [RF_TIME_W-1:0] mc_rf_start_time_cfg,
  input  logic [RF_TIME_W-1:0] mc_rf_period_time_cfg,
  output logic                 rf_req,
  output logic                 rf_urgent,
  input  logic                 rf_grant,
  output logic                 rf_start,
  input  logic                 rf_finish,
  output logic                 rf_busy,
  output logic [PEND_W-1:0]    rf_pend_cnt,
  output logic                 rf_overflow,
  input  logic                 rf_overflow_clr
);

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  rf_state_e         state_r;
  logic              req_r;
  logic              start_r;
  logic              busy_r;
  logic [PEND_W-1:0] pend_cnt_r;
  logic [PEND_W-1:0] pend_nxt_s;
  logic              ovf_set_s;
  logic              overflow_r;
  logic              tick_s;

  mc_rf_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .mc_rf_en   (mc_rf_en),
    .start_cfg  (mc_rf_start_time_cfg),
    .period_cfg (mc_rf_period_time_cfg),
    .tick       (tick_s)
  );

  // Next pending count: tick adds, start removes, both together cancel; saturate at max.
  always_comb begin
    pend_nxt_s = pend_cnt_r;
    ovf_set_s  = 1'b0;
    if (tick_s && !start_r) begin
      if (pend_cnt_r == PEND_MAX) begin
        pend_nxt_s = pend_cnt_r;
        ovf_set_s  = 1'b1;
      end else begin
        pend_nxt_s = pend_cnt_r + PEND_ONE;
      end
    end else if (start_r && !tick_s) begin
      if (pend_cnt_r != {PEND_W{1'b0}}) begin
        pend_nxt_s = pend_cnt_r - PEND_ONE;
      end else begin
        pend_nxt_s = pend_cnt_r;
      end
    end else begin
      pend_nxt_s = pend_cnt_r;
    end
  end

  // Pending counter and sticky overflow; a new overflow beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt_r <= {PEND_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      pend_cnt_r <= pend_nxt_s;
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (rf_overflow_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Request/start/busy FSM with outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      start_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pend_cnt_r != {PEND_W{1'b0}}) begin
            state_r <= REQ;
            req_r   <= 1'b1;
          end
        end
        REQ: begin
          if (rf_grant) begin
            state_r <= START;
            req_r   <= 1'b0;
            start_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          state_r <= BUSY;
          start_r <= 1'b0;
        end
        BUSY: begin
          if (rf_finish) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
          start_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rf_req      = req_r;
  assign rf_start    = start_r;
  assign rf_busy     = busy_r;
  assign rf_pend_cnt = pend_cnt_r;
  assign rf_overflow = overflow_r;

`ifdef MC_RF_URGENT_EN
  assign rf_urgent = req_r & (pend_cnt_r >= PEND_W'(URGENT_THR));
`else
  logic unused_thr_s;
  assign unused_thr_s = |(32'(URGENT_THR));
  assign rf_urgent    = 1'b0;
`endif

endmodule

// File: tb/tb_mc_rf_scheduler.sv
// Directed self-checking bench for mc_rf_scheduler.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mc_rf_scheduler;

  logic        clk;
  logic        rst;
  logic        mc_rf_en;
  logic [27:0] start_cfg;
  logic [27:0] period_cfg;
  logic        rf_req;
  logic        rf_urgent;
  logic        rf_grant;
  logic        rf_start;
  logic        rf_finish;
  logic        rf_busy;
  logic [3:0]  rf_pend_cnt;
  logic        rf_overflow;
  logic        rf_overflow_clr;

  int errors;
  int checks;
  logic found;

`ifdef MC_RF_URGENT_EN
  localparam logic URG_EXP = 1'b1;
`else
  localparam logic URG_EXP = 1'b0;
`endif

  mc_rf_scheduler dut (
    .clk                   (clk),
    .rst                   (rst),
    .mc_rf_en              (mc_rf_en),
    .mc_rf_start_time_cfg  (start_cfg),
    .mc_rf_period_time_cfg (period_cfg),
    .rf_req                (rf_req),
    .rf_urgent             (rf_urgent),
    .rf_grant              (rf_grant),
    .rf_start              (rf_start),
    .rf_finish             (rf_finish),
    .rf_busy               (rf_busy),
    .rf_pend_cnt           (rf_pend_cnt),
    .rf_overflow           (rf_overflow),
    .rf_overflow_clr       (rf_overflow_clr)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence; Pn below means the n-th rising edge after the step's setup.
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; mc_rf_en = 1'b0; start_cfg = 28'd0; period_cfg = 28'd0;
    rf_grant = 1'b0; rf_finish = 1'b0; rf_overflow_clr = 1'b0;
    cyc(3);
    chk("rst_req", {31'd0, rf_req}, 32'd0);
    chk("rst_start", {31'd0, rf_start}, 32'd0);
    chk("rst_busy", {31'd0, rf_busy}, 32'd0);
    chk("rst_pend", {28'd0, rf_pend_cnt}, 32'd0);
    chk("rst_ovf", {31'd0, rf_overflow}, 32'd0);
    chk("rst_urg", {31'd0, rf_urgent}, 32'd0);

    // Step 1: start=5 period=10, grant tied high. Load at P0, tick after P5, start at P8.
    rst = 1'b0; start_cfg = 28'd5; period_cfg = 28'd10; rf_grant = 1'b1; mc_rf_en = 1'b1;
    cyc(8);
    chk("t1_req", {31'd0, rf_req}, 32'd1);
    chk("t1_nostart", {31'd0, rf_start}, 32'd0);
    cyc(1);
    chk("t1_start", {31'd0, rf_start}, 32'd1);
    chk("t1_pend_in_start", {28'd0, rf_pend_cnt}, 32'd1);
    chk("t1_busy_start", {31'd0, rf_busy}, 32'd1);
    cyc(1);
    chk("t1_start_pulse", {31'd0, rf_start}, 32'd0);
    chk("t1_pend_dec", {28'd0, rf_pend_cnt}, 32'd0);
    chk("t1_busy", {31'd0, rf_busy}, 32'd1);
    rf_finish = 1'b1;
    cyc(1);
    rf_finish = 1'b0;
    chk("t1_idle", {31'd0, rf_busy}, 32'd0);
    chk("t1_idle_req", {31'd0, rf_req}, 32'd0);
    cyc(7);
    chk("t1_req2", {31'd0, rf_req}, 32'd1);
    chk("t1_nostart2", {31'd0, rf_start}, 32'd0);
    cyc(1);
    chk("t1_start2", {31'd0, rf_start}, 32'd1);
    cyc(1);
    rf_finish = 1'b1;
    cyc(1);
    rf_finish = 1'b0; mc_rf_en = 1'b0;

    // Step 2: grant low, start=0 period=3. Ticks after P0,P3,..; pend=8 at P22, overflow at P25.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; start_cfg = 28'd0; period_cfg = 28'd3; rf_grant = 1'b0; mc_rf_en = 1'b1;
    cyc(2);
    chk("t2_pend1", {28'd0, rf_pend_cnt}, 32'd1);
    chk("t2_req_late", {31'd0, rf_req}, 32'd0);
    cyc(1);
    chk("t2_req", {31'd0, rf_req}, 32'd1);
    cyc(11);
    chk("t2_pend5", {28'd0, rf_pend_cnt}, 32'd5);
    chk("t2_urg_below", {31'd0, rf_urgent}, 32'd0);
    cyc(3);
    chk("t2_pend6", {28'd0, rf_pend_cnt}, 32'd6);
    chk("t2_urg_thr", {31'd0, rf_urgent}, {31'd0, URG_EXP});
    cyc(8);
    chk("t2_pend_sat", {28'd0, rf_pend_cnt}, 32'd8);
    chk("t2_ovf_pre", {31'd0, rf_overflow}, 32'd0);
    cyc(1);
    chk("t2_ovf", {31'd0, rf_overflow}, 32'd1);
    chk("t2_pend_hold", {28'd0, rf_pend_cnt}, 32'd8);
    cyc(4);
    rf_overflow_clr = 1'b1;
    cyc(1);
    chk("t2_ovf_clr", {31'd0, rf_overflow}, 32'd0);
    cyc(1);
    chk("t2_ovf_wins", {31'd0, rf_overflow}, 32'd1);
    mc_rf_en = 1'b0;
    cyc(1);
    rf_overflow_clr = 1'b0;
    chk("t2_ovf_clr2", {31'd0, rf_overflow}, 32'd0);
    chk("t2_pend_final", {28'd0, rf_pend_cnt}, 32'd8);
    chk("t2_urg_sat", {31'd0, rf_urgent}, {31'd0, URG_EXP});
    chk("t2_nostart", {31'd0, rf_start}, 32'd0);

    // Step 4: grant once, reach BUSY with pend=7, then reset mid-refresh.
    rf_grant = 1'b1;
    cyc(1);
    rf_grant = 1'b0;
    chk("t4_start", {31'd0, rf_start}, 32'd1);
    cyc(1);
    chk("t4_busy_pend", {28'd0, rf_pend_cnt}, 32'd7);
    rst = 1'b1;
    cyc(1);
    chk("t4_rst_busy", {31'd0, rf_busy}, 32'd0);
    chk("t4_rst_pend", {28'd0, rf_pend_cnt}, 32'd0);
    chk("t4_rst_req", {31'd0, rf_req}, 32'd0);
    rst = 1'b0; rf_finish = 1'b1;
    cyc(1);
    rf_finish = 1'b0;
    cyc(2);
    chk("t4_fin_ignored_busy", {31'd0, rf_busy}, 32'd0);
    chk("t4_fin_ignored_req", {31'd0, rf_req}, 32'd0);
    chk("t4_fin_ignored_start", {31'd0, rf_start}, 32'd0);

    // Step 3: start=0 period=3 grant high; START at P3 coincides with the second tick.
    start_cfg = 28'd0; period_cfg = 28'd3; rf_grant = 1'b1; mc_rf_en = 1'b1;
    cyc(4);
    chk("t3_start", {31'd0, rf_start}, 32'd1);
    chk("t3_pend_start", {28'd0, rf_pend_cnt}, 32'd1);
    cyc(1);
    chk("t3_pend_same", {28'd0, rf_pend_cnt}, 32'd1);
    chk("t3_busy", {31'd0, rf_busy}, 32'd1);
    mc_rf_en = 1'b0; rf_finish = 1'b1;
    cyc(1);
    rf_finish = 1'b0;
    chk("t3_idle", {31'd0, rf_busy}, 32'd0);
    chk("t3_idle_req", {31'd0, rf_req}, 32'd0);
    cyc(1);
    chk("t3_req2", {31'd0, rf_req}, 32'd1);
    cyc(1);
    chk("t3_start2", {31'd0, rf_start}, 32'd1);
    cyc(1);
    chk("t3_pend0", {28'd0, rf_pend_cnt}, 32'd0);
    rf_finish = 1'b1;
    cyc(1);
    rf_finish = 1'b0;
    cyc(2);
    chk("t3_no_req", {31'd0, rf_req}, 32'd0);

    // Step 5: period=0 ticks every cycle; drop enable and drain the backlog.
    rf_grant = 1'b0; start_cfg = 28'd0; period_cfg = 28'd0; mc_rf_en = 1'b1;
    cyc(4);
    chk("t5_pend3", {28'd0, rf_pend_cnt}, 32'd3);
    mc_rf_en = 1'b0;
    cyc(1);
    chk("t5_en_drop", {28'd0, rf_pend_cnt}, 32'd3);
    cyc(2);
    chk("t5_no_tick", {28'd0, rf_pend_cnt}, 32'd3);
    rf_grant = 1'b1;
    for (int r = 0; r < 3; r++) begin
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
        cyc(1);
        if (rf_start) found = 1'b1;
      end
      chk("t5_start_seen", {31'd0, found}, 32'd1);
      cyc(1);
      chk("t5_drain", {28'd0, rf_pend_cnt}, 32'(2 - r));
      rf_finish = 1'b1;
      cyc(1);
      rf_finish = 1'b0;
    end
    cyc(3);
    chk("t5_pend_empty", {28'd0, rf_pend_cnt}, 32'd0);
    chk("t5_req_done", {31'd0, rf_req}, 32'd0);
    chk("t5_busy_done", {31'd0, rf_busy}, 32'd0);
    chk("t5_ovf", {31'd0, rf_overflow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
